updater: RTL and testbench



---
 rtl/octree_pkg.sv | 32 +++
 rtl/updater_if.sv | 26 ++
 rtl/sram.sv | 35 +++
 rtl/updater_addr_gen.sv | 35 +++
 rtl/updater.sv | 173 +++++++++++++++++
 tb/tb_updater.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/octree_pkg.sv
// Shared octree parameters, derived memory map, FSM state encoding and child-index helper.
package octree_pkg;
    localparam int DIMENTION          = 3;
    localparam int DATA_WIDTH         = 16;
    localparam int CONTROL_WIDTH      = 3;
    localparam int SELECT_WIDTH       = 2;
    localparam int DATA_BUS_WIDTH     = 64;
    localparam int ADDR_BUS_WIDTH     = 64;
    localparam int FEATURE_LENTH      = 9;
    localparam int CHILDREN_NUM       = 8;
    localparam int LOG_CHILD_NUM      = 3;
    localparam int TREE_LEVEL         = 5;
    localparam int LOG_TREE_LEVEL     = 3;
    localparam int TREE_ADDR_START    = 4;
    localparam int FEATURE_START_ADDR = 4;
    localparam int ENCODE_ADDR_WIDTH  = LOG_CHILD_NUM * TREE_LEVEL + LOG_TREE_LEVEL;
    localparam int NODE_NUM           = (CHILDREN_NUM ** TREE_LEVEL - 1) / (CHILDREN_NUM - 1);
    localparam int FEATURE_BASE       = TREE_ADDR_START + NODE_NUM + FEATURE_START_ADDR;
    localparam int IDX_WIDTH          = 16;
    localparam int CNT_WIDTH          = $clog2(FEATURE_LENTH);

    typedef logic [IDX_WIDTH-1:0] idx_t;

    typedef enum logic [3:0] {
        IDLE, ADD_CAP, ADD_RD, ADD_WR, FEAT_WR, DEL_CLR, DEL_RD, DEL_WR, DONE
    } state_e;

    // Breadth-first numbering: child c of node i is 8i+1+c.
    function automatic idx_t child_index(input idx_t parent, input logic [LOG_CHILD_NUM-1:0] c);
        return (parent << LOG_CHILD_NUM) + idx_t'(c) + idx_t'(1);
    endfunction
endpackage

// File: rtl/updater_if.sv
// Command strobes, feature stream and single-port SRAM bus of the anchor updater.
interface updater_if;
    import octree_pkg::*;

    logic                         add_anchor;
    logic                         del_anchor;
    logic                         add_done;
    logic                         del_done;
    logic [ENCODE_ADDR_WIDTH-1:0] pos_encode;
    logic [DATA_BUS_WIDTH-1:0]    feature_in;
    logic                         mem_sram_CEN;
    logic                         mem_sram_GWEN;
    logic [ADDR_BUS_WIDTH-1:0]    mem_sram_A;
    logic [DATA_BUS_WIDTH-1:0]    mem_sram_D;
    logic [DATA_BUS_WIDTH-1:0]    mem_sram_Q;

    modport master (
        output add_anchor, del_anchor, pos_encode, feature_in,
        input  add_done, del_done, mem_sram_CEN, mem_sram_GWEN, mem_sram_A, mem_sram_D, mem_sram_Q
    );

    modport slave (
        input  add_anchor, del_anchor, pos_encode, feature_in, mem_sram_Q,
        output add_done, del_done, mem_sram_CEN, mem_sram_GWEN, mem_sram_A, mem_sram_D
    );
endinterface

// File: rtl/sram.sv
// Single-port SRAM model: registered 1-cycle read, write on CEN=0/GWEN=0, out-of-range ignored.
module sram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_DEPTH  = 20280
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_sram_CEN,
    input  logic [ADDR_WIDTH-1:0] mem_sram_A,
    input  logic [DATA_WIDTH-1:0] mem_sram_D,
    input  logic                  mem_sram_GWEN,
    output logic [DATA_WIDTH-1:0] mem_sram_Q
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;

    assign in_range = mem_sram_A < ADDR_WIDTH'(MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (!mem_sram_CEN && !mem_sram_GWEN && in_range) begin
            mem[mem_sram_A[IDX_W-1:0]] <= mem_sram_D;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mem_sram_Q <= '0;
        end else if (!mem_sram_CEN && mem_sram_GWEN) begin
            mem_sram_Q <= in_range ? mem[mem_sram_A[IDX_W-1:0]] : '0;
        end
    end
endmodule

// File: rtl/updater_addr_gen.sv
// Decodes a node path into per-level bitmap addresses and the node's feature base address.
module updater_addr_gen
    import octree_pkg::*;
(
    input  logic [ENCODE_ADDR_WIDTH-1:0] pos_i,
    output logic [LOG_TREE_LEVEL-1:0]    level_o,
    output logic [LOG_CHILD_NUM-1:0]     digit_o    [TREE_LEVEL],
    output logic [ADDR_BUS_WIDTH-1:0]    bmp_addr_o [TREE_LEVEL],
    output logic [ADDR_BUS_WIDTH-1:0]    feat_addr_o
);
    idx_t node_idx;

    assign level_o = pos_i[ENCODE_ADDR_WIDTH-1 -: LOG_TREE_LEVEL];

    for (genvar j = 0; j < TREE_LEVEL; j++) begin : g_digit
        assign digit_o[j] = pos_i[ENCODE_ADDR_WIDTH-LOG_TREE_LEVEL-1-j*LOG_CHILD_NUM -: LOG_CHILD_NUM];
    end

    // Walk root-down; entry j is the ancestor at level j, entry L the node itself.
    always_comb begin
        idx_t cur;
        cur      = '0;
        node_idx = '0;
        for (int j = 0; j < TREE_LEVEL; j++) begin
            bmp_addr_o[j] = ADDR_BUS_WIDTH'(TREE_ADDR_START) + ADDR_BUS_WIDTH'(cur);
            if (LOG_TREE_LEVEL'(j) == level_o) begin
                node_idx = cur;
            end
            cur = child_index(cur, digit_o[j]);
        end
    end

    assign feat_addr_o = ADDR_BUS_WIDTH'(FEATURE_BASE)
                       + ADDR_BUS_WIDTH'(node_idx) * ADDR_BUS_WIDTH'(FEATURE_LENTH);
endmodule

// File: rtl/updater.sv
// Octree anchor add/delete engine over a single-port SRAM; 2 cycles per bitmap level, commands only in IDLE.
// UPDATER_FEATURE_CLEAR_EN: delete also zeroes the node's feature words before completing.
module updater
    import octree_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    updater_if.slave bus
);
`ifdef UPDATER_FEATURE_CLEAR_EN
    localparam state_e DEL_END = FEAT_WR;
`else
    localparam state_e DEL_END = DONE;
`endif

    state_e                       state_q, state_d;
    logic [ENCODE_ADDR_WIDTH-1:0] pos_q, pos_d;
    logic                         del_q, del_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [LOG_TREE_LEVEL-1:0]    lvl_q, lvl_d;
    logic [DATA_BUS_WIDTH-1:0]    stage_q;
    logic [DATA_BUS_WIDTH-1:0]    fbuf_q [FEATURE_LENTH];
    logic [DATA_BUS_WIDTH-1:0]    fbuf_d [FEATURE_LENTH];

    logic [LOG_TREE_LEVEL-1:0]    level;
    logic [LOG_CHILD_NUM-1:0]     digit    [TREE_LEVEL];
    logic [ADDR_BUS_WIDTH-1:0]    bmp_addr [TREE_LEVEL];
    logic [ADDR_BUS_WIDTH-1:0]    feat_addr;
    logic [CHILDREN_NUM-1:0]      lvl_bit;
    logic [CHILDREN_NUM-1:0]      del_mask;
    logic                         last_cnt;

    logic                         cen, gwen;
    logic [ADDR_BUS_WIDTH-1:0]    addr;
    logic [DATA_BUS_WIDTH-1:0]    wdat;

    updater_addr_gen u_addr_gen (
        .pos_i       (pos_q),
        .level_o     (level),
        .digit_o     (digit),
        .bmp_addr_o  (bmp_addr),
        .feat_addr_o (feat_addr)
    );

    assign lvl_bit  = CHILDREN_NUM'(1) << digit[lvl_q];
    assign del_mask = bus.mem_sram_Q[CHILDREN_NUM-1:0] & ~lvl_bit;
    assign last_cnt = cnt_q == CNT_WIDTH'(FEATURE_LENTH - 1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        del_d   = del_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        fbuf_d  = fbuf_q;
        cen     = 1'b1;
        gwen    = 1'b1;
        addr    = '0;
        wdat    = '0;
        case (state_q)
            IDLE: begin
                if (bus.add_anchor || bus.del_anchor) begin
                    pos_d = bus.pos_encode;
                    del_d = !bus.add_anchor;
                    cnt_d = '0;
                    lvl_d = '0;
                    if (bus.pos_encode[ENCODE_ADDR_WIDTH-1 -: LOG_TREE_LEVEL] >= LOG_TREE_LEVEL'(TREE_LEVEL)) begin
                        state_d = DONE;
                    end else begin
                        state_d = bus.add_anchor ? ADD_CAP : DEL_CLR;
                    end
                end
            end
            // stage_q lags feature_in by one cycle, so slot 0 holds the accept-cycle word.
            ADD_CAP: begin
                fbuf_d[cnt_q] = stage_q;
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = (level == '0) ? FEAT_WR : ADD_RD;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ADD_RD: begin
                cen     = 1'b0;
                addr    = bmp_addr[lvl_q];
                state_d = ADD_WR;
            end
            ADD_WR: begin
                cen  = 1'b0;
                gwen = 1'b0;
                addr = bmp_addr[lvl_q];
                wdat = DATA_BUS_WIDTH'(bus.mem_sram_Q[CHILDREN_NUM-1:0] | lvl_bit);
                if (lvl_q == level - LOG_TREE_LEVEL'(1)) begin
                    state_d = FEAT_WR;
                end else begin
                    lvl_d   = lvl_q + LOG_TREE_LEVEL'(1);
                    state_d = ADD_RD;
                end
            end
            FEAT_WR: begin
                cen  = 1'b0;
                gwen = 1'b0;
                addr = feat_addr + ADDR_BUS_WIDTH'(cnt_q);
                wdat = del_q ? '0 : fbuf_q[cnt_q];
                if (last_cnt) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            DEL_CLR: begin
                cen   = 1'b0;
                gwen  = 1'b0;
                addr  = bmp_addr[level];
                cnt_d = '0;
                if (level == '0) begin
                    state_d = DEL_END;
                end else begin
                    lvl_d   = level - LOG_TREE_LEVEL'(1);
                    state_d = DEL_RD;
                end
            end
            DEL_RD: begin
                cen     = 1'b0;
                addr    = bmp_addr[lvl_q];
                state_d = DEL_WR;
            end
            // An emptied non-root parent is pruned by climbing one more level.
            DEL_WR: begin
                cen  = 1'b0;
                gwen = 1'b0;
                addr = bmp_addr[lvl_q];
                wdat = DATA_BUS_WIDTH'(del_mask);
                if (del_mask == '0 && lvl_q != '0) begin
                    lvl_d   = lvl_q - LOG_TREE_LEVEL'(1);
                    state_d = DEL_RD;
                end else begin
                    state_d = DEL_END;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            del_q   <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= '0;
            stage_q <= '0;
            fbuf_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            del_q   <= del_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            stage_q <= bus.feature_in;
            fbuf_q  <= fbuf_d;
        end
    end

    assign bus.add_done      = (state_q == DONE) && !del_q;
    assign bus.del_done      = (state_q == DONE) && del_q;
    assign bus.mem_sram_CEN  = cen;
    assign bus.mem_sram_GWEN = gwen;
    assign bus.mem_sram_A    = addr;
    assign bus.mem_sram_D    = wdat;
endmodule

// File: tb/tb_updater.sv
// Directed bench for updater + sram: SRAM write trace, done timing and final bitmap words.
module tb_updater;
    import octree_pkg::*;

    localparam int BUDGET = 40;
`ifdef UPDATER_FEATURE_CLEAR_EN
    localparam int XC = FEATURE_LENTH;
`else
    localparam int XC = 0;
`endif

    // {L, d0, d1, d2, d3, d4}
    localparam logic [17:0] P12   = {3'd2, 3'd0, 3'd3, 3'd1, 3'd0, 3'd0};
    localparam logic [17:0] P6    = {3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
    localparam logic [17:0] PROOT = {3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    localparam logic [17:0] PL6   = {3'd6, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    localparam logic [17:0] PL7   = {3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    logic clk = 1'b0;
    logic rst;

    logic [63:0] wa [64];
    logic [63:0] wd [64];
    int n_wr, n_cen, n_add, n_del, done_at;
    int n_checks = 0;
    int n_errors = 0;

    updater_if bus ();

    updater u_dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    sram #(
        .DATA_WIDTH (DATA_BUS_WIDTH),
        .ADDR_WIDTH (ADDR_BUS_WIDTH),
        .MEM_DEPTH  (20280)
    ) u_sram (
        .clk           (clk),
        .rst_n         (rst),
        .mem_sram_CEN  (bus.mem_sram_CEN),
        .mem_sram_A    (bus.mem_sram_A),
        .mem_sram_D    (bus.mem_sram_D),
        .mem_sram_GWEN (bus.mem_sram_GWEN),
        .mem_sram_Q    (bus.mem_sram_Q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, then trace BUDGET cycles; c counts cycles after the accept edge (c=1 is the next cycle).
    task automatic run_cmd(input logic add, input logic del, input logic [17:0] pos,
                           input logic [63:0] fbase, input bit poke);
        @(negedge clk);
        bus.add_anchor = add;
        bus.del_anchor = del;
        bus.pos_encode = pos;
        bus.feature_in = fbase;
        n_wr = 0; n_cen = 0; n_add = 0; n_del = 0; done_at = -1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (!bus.mem_sram_CEN) n_cen++;
            if (!bus.mem_sram_CEN && !bus.mem_sram_GWEN && n_wr < 64) begin
                wa[n_wr] = bus.mem_sram_A;
                wd[n_wr] = bus.mem_sram_D;
                n_wr++;
            end
            if (bus.add_done) begin
                n_add++;
                if (done_at < 0) done_at = c;
            end
            if (bus.del_done) begin
                n_del++;
                if (done_at < 0) done_at = c;
            end
            bus.add_anchor = poke && (c == 5);
            bus.del_anchor = poke && (c == 5);
            bus.pos_encode = 18'h3ffff;
            bus.feature_in = (c < FEATURE_LENTH) ? fbase + 64'(c) : 64'hdead_beef;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.add_anchor = 1'b0;
        bus.del_anchor = 1'b0;
        bus.pos_encode = '0;
        bus.feature_in = '0;
        repeat (2) @(negedge clk);
        check("rst_add_done", 64'(bus.add_done), 64'd0);
        check("rst_del_done", 64'(bus.del_done), 64'd0);
        check("rst_cen", 64'(bus.mem_sram_CEN), 64'd1);
        check("rst_gwen", 64'(bus.mem_sram_GWEN), 64'd1);
        check("rst_addr", bus.mem_sram_A, 64'd0);
        check("rst_data", bus.mem_sram_D, 64'd0);
        rst = 1'b0;
        n_cen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.mem_sram_CEN) n_cen++;
        end
        check("idle_cen_low_cycles", 64'(n_cen), 64'd0);

        // Delete node 12 on zeroed memory: clear own word, then parent 1 empties, then root.
        run_cmd(1'b0, 1'b1, P12, 64'd0, 1'b0);
        check("del12_nwr", 64'(n_wr), 64'(3 + XC));
        check("del12_w0_addr", wa[0], 64'd16);
        check("del12_w0_data", wd[0], 64'd0);
        check("del12_w1_addr", wa[1], 64'd5);
        check("del12_w2_addr", wa[2], 64'd4);
        check("del12_w2_data", wd[2], 64'd0);
        check("del12_done_at", 64'(done_at), 64'(6 + XC));
        check("del12_ndel", 64'(n_del), 64'd1);
        check("del12_nadd", 64'(n_add), 64'd0);

        // Add node 12 with features 10..18.
        run_cmd(1'b1, 1'b0, P12, 64'd10, 1'b0);
        check("add12_nwr", 64'(n_wr), 64'd11);
        check("add12_w0_addr", wa[0], 64'd4);
        check("add12_w0_data", wd[0], 64'h01);
        check("add12_w1_addr", wa[1], 64'd5);
        check("add12_w1_data", wd[1], 64'h08);
        for (int k = 0; k < FEATURE_LENTH; k++) begin
            check($sformatf("add12_feat%0d_addr", k), wa[2 + k], 64'(4797 + k));
            check($sformatf("add12_feat%0d_data", k), wd[2 + k], 64'(10 + k));
        end
        check("add12_done_at", 64'(done_at), 64'd23);
        check("add12_nadd", 64'(n_add), 64'd1);
        check("add12_mem4", u_sram.mem[4], 64'h01);
        check("add12_mem5", u_sram.mem[5], 64'h08);
        check("add12_mem4805", u_sram.mem[4805], 64'd18);

        // Add node 6 (root bit 5) with features 20..28, then delete it.
        run_cmd(1'b1, 1'b0, P6, 64'd20, 1'b0);
        check("add6_w0_addr", wa[0], 64'd4);
        check("add6_w0_data", wd[0], 64'h21);
        check("add6_w1_addr", wa[1], 64'd4743);
        check("add6_w1_data", wd[1], 64'd20);
        check("add6_nwr", 64'(n_wr), 64'd10);
        check("add6_done_at", 64'(done_at), 64'd21);
        run_cmd(1'b0, 1'b1, P6, 64'd0, 1'b0);
        check("del6_w0_addr", wa[0], 64'd10);
        check("del6_w1_addr", wa[1], 64'd4);
        check("del6_w1_data", wd[1], 64'h01);
        check("del6_nwr", 64'(n_wr), 64'(2 + XC));
        check("del6_done_at", 64'(done_at), 64'(4 + XC));
        check("del6_mem4", u_sram.mem[4], 64'h01);
        check("del6_mem5", u_sram.mem[5], 64'h08);

        // Simultaneous strobes at level 0 (add wins), plus strobes while busy.
        run_cmd(1'b1, 1'b1, PROOT, 64'd40, 1'b1);
        check("both_nadd", 64'(n_add), 64'd1);
        check("both_ndel", 64'(n_del), 64'd0);
        check("both_done_at", 64'(done_at), 64'd19);
        check("both_nwr", 64'(n_wr), 64'd9);
        check("both_w0_addr", wa[0], 64'd4689);
        check("both_w8_addr", wa[8], 64'd4697);
        check("both_w8_data", wd[8], 64'd48);
        check("both_mem4", u_sram.mem[4], 64'h01);

        // Out-of-range levels: no SRAM access, done the next cycle.
        run_cmd(1'b0, 1'b1, PL6, 64'd0, 1'b0);
        check("l6_done_at", 64'(done_at), 64'd1);
        check("l6_ndel", 64'(n_del), 64'd1);
        check("l6_cen_low_cycles", 64'(n_cen), 64'd0);
        run_cmd(1'b1, 1'b0, PL7, 64'd0, 1'b0);
        check("l7_done_at", 64'(done_at), 64'd1);
        check("l7_nadd", 64'(n_add), 64'd1);
        check("l7_cen_low_cycles", 64'(n_cen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
